// File: rtl/jt51_so_pkg.sv
// Shared constants and FSM state type for the JT51 serial DAC link receiver.
package jt51_so_pkg;
  localparam int SLOT_BITS = 16;
  localparam int PAD_BITS  = 3;
  localparam int MAN_W     = 10;
  localparam int EXP_W     = 3;
  localparam int MAN_LSB   = PAD_BITS;
  localparam int EXP_LSB   = PAD_BITS + MAN_W;
  localparam int OUT_W     = 16;
  localparam int CNT_W     = 5;

  typedef enum logic [2:0] {IDLE, LSLOT, RSLOT, CHECK, ERR} state_t;
endpackage

// File: rtl/jt51_exp2lin.sv
// Combinational expander: 10-bit signed mantissa + 3-bit exponent to 16-bit linear.
module jt51_exp2lin
  import jt51_so_pkg::*;
(
  input  logic signed [MAN_W-1:0] man,
  input  logic        [EXP_W-1:0] ex,
  output logic signed [OUT_W-1:0] lin
);
  logic signed [OUT_W-1:0] man_ext;

  assign man_ext = OUT_W'(man);

  always_comb begin
    lin = '0;
    if (ex != '0)
      lin = man_ext <<< (ex - 3'd1);
  end
endmodule

// File: rtl/jt51_so_rx.sv
// JT51 SO/SH1/SH2 receiver: deserialises per-channel slots, expands them to
// linear samples and flags malformed slots.
module jt51_so_rx
  import jt51_so_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cen,
  input  logic                    so,
  input  logic                    sh1,
  input  logic                    sh2,
  output logic signed [OUT_W-1:0] left,
  output logic signed [OUT_W-1:0] right,
  output logic                    left_ok,
  output logic                    right_ok,
  output logic                    frame_err
);
  localparam logic [CNT_W-1:0] SLOT_CNT = CNT_W'(SLOT_BITS);

  state_t                  state, state_nx;
  logic                    sh1_p0, sh2_p0;
  logic                    chan_p0;
  logic [CNT_W-1:0]        cnt_p0;
  logic [SLOT_BITS-1:0]    sr_p0;
  logic                    start_l, start_r, shift, judge, err_set;
  logic                    both, rise1, rise2, strobe;
  logic signed [OUT_W-1:0] lin;
  logic                    unused_pad;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign both       = sh1 & sh2;
  assign rise1      = sh1 & ~sh1_p0;
  assign rise2      = sh2 & ~sh2_p0;
  assign strobe     = chan_p0 ? sh2 : sh1;
  assign unused_pad = ^sr_p0[PAD_BITS-1:0];

  always_comb begin
    state_nx = state;
    start_l  = 1'b0;
    start_r  = 1'b0;
    shift    = 1'b0;
    judge    = 1'b0;
    err_set  = 1'b0;
    unique case (state)
      LSLOT, RSLOT: if (cen) begin
        if (both) begin
          state_nx = ERR;
          err_set  = 1'b1;
        end else if (strobe) begin
          shift = 1'b1;
        end else begin
          state_nx = CHECK;
        end
      end
      ERR: if (cen && !sh1 && !sh2) state_nx = IDLE;
      CHECK: begin
        judge    = 1'b1;
        state_nx = IDLE;
      end
      default: ;
    endcase
    // A new slot may open from IDLE or while the previous one is being judged
    if ((state == IDLE || state == CHECK) && cen) begin
      if (both) begin
        state_nx = ERR;
        err_set  = 1'b1;
      end else if (rise1) begin
        state_nx = LSLOT;
        start_l  = 1'b1;
      end else if (rise2) begin
        state_nx = RSLOT;
        start_r  = 1'b1;
      end
    end
  end

  jt51_exp2lin u_exp2lin (
    .man (sr_p0[MAN_LSB +: MAN_W]),
    .ex  (sr_p0[EXP_LSB +: EXP_W]),
    .lin (lin)
  );

  // stage p0: strobe history, FSM, bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sh1_p0    <= 1'b0;
      sh2_p0    <= 1'b0;
      chan_p0   <= 1'b0;
      cnt_p0    <= '0;
      left      <= '0;
      right     <= '0;
      left_ok   <= 1'b0;
      right_ok  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      left_ok   <= 1'b0;
      right_ok  <= 1'b0;
      frame_err <= err_set | (judge && cnt_p0 != SLOT_CNT);
      if (cen) begin
        sh1_p0 <= sh1;
        sh2_p0 <= sh2;
      end
      if (start_l || start_r) begin
        cnt_p0  <= CNT_W'(1);
        chan_p0 <= start_r;
      end else if (shift) begin
        cnt_p0 <= sat_inc(cnt_p0);
      end
      // stage p1: judged slot lands on its channel output
      if (judge && cnt_p0 == SLOT_CNT) begin
        if (chan_p0) begin
          right    <= lin;
          right_ok <= 1'b1;
        end else begin
          left     <= lin;
          left_ok  <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start_l || start_r || shift)
      sr_p0 <= {so, sr_p0[SLOT_BITS-1:1]};
  end
endmodule

// File: tb/tb_jt51_so_rx.sv
// Directed bench for jt51_so_rx: slot decode, latency, malformed slots and reset.
module tb_jt51_so_rx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b0;
  logic        so = 1'b0;
  logic        sh1 = 1'b0;
  logic        sh2 = 1'b0;
  logic [15:0] left, right;
  logic        left_ok, right_ok, frame_err;

  int n_chk = 0;
  int n_err = 0;
  int n_l = 0, n_r = 0, n_f = 0, n_wide = 0;
  int e_l = 0, e_r = 0, e_f = 0;
  int cyc = 0, t_l = 0, t_r = 0;
  logic pl = 1'b0, pr = 1'b0, pf = 1'b0;
  logic [31:0] r_hist = '0;

  jt51_so_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cen       (cen),
    .so        (so),
    .sh1       (sh1),
    .sh2       (sh2),
    .left      (left),
    .right     (right),
    .left_ok   (left_ok),
    .right_ok  (right_ok),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // pulse monitor: counts, width, order and right-value history
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (left_ok) begin
      n_l = n_l + 1;
      t_l = cyc;
    end
    if (right_ok) begin
      n_r = n_r + 1;
      t_r = cyc;
      r_hist = {r_hist[15:0], right};
    end
    if (frame_err) n_f = n_f + 1;
    if ((left_ok && pl) || (right_ok && pr) || (frame_err && pf)) n_wide = n_wide + 1;
    pl = left_ok;
    pr = right_ok;
    pf = frame_err;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int div);
    for (int i = 0; i < div; i++) begin
      cen = (i == 0);
      @(posedge clk);
      #1;
    end
    cen = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_slot(input logic ch, input logic [9:0] man, input logic [2:0] ex,
                           input int nbits, input int div);
    logic [15:0] fr;
    fr = {ex, man, 3'b101};
    for (int k = 0; k < nbits; k++) begin
      so = fr[k % 16];
      if (ch) sh2 = 1'b1; else sh1 = 1'b1;
      step(div);
    end
    sh1 = 1'b0;
    sh2 = 1'b0;
    so  = 1'b0;
    step(div);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1);
  endtask

  task automatic check_counts(input string tag);
    check_eq({tag, "_lok"}, n_l, e_l);
    check_eq({tag, "_rok"}, n_r, e_r);
    check_eq({tag, "_ferr"}, n_f, e_f);
  endtask

  initial begin
    repeat (3) tick();
    check_eq("rst_left", left, 16'h0000);
    check_eq("rst_right", right, 16'h0000);
    check_eq("rst_pulses", {left_ok, right_ok, frame_err}, 3'b000);
    rst_n = 1'b1;
    idle(2);

    // 1: exact latency of a left update
    send_slot(1'b0, 10'h1FF, 3'd7, 16, 1);
    check_eq("t1_pre_left", left, 16'h0000);
    check_eq("t1_pre_ok", left_ok, 1'b0);
    tick();
    check_eq("t1_left", left, 16'h7FC0);
    check_eq("t1_ok_hi", left_ok, 1'b1);
    tick();
    check_eq("t1_ok_lo", left_ok, 1'b0);
    check_eq("t1_right", right, 16'h0000);
    e_l = e_l + 1;
    idle(2);
    check_counts("t1");

    // 2: back-to-back right slots, second opens while the first is judged
    send_slot(1'b1, 10'h200, 3'd1, 16, 1);
    send_slot(1'b1, 10'h200, 3'd0, 16, 1);
    idle(3);
    e_r = e_r + 2;
    check_eq("t2_hist", r_hist, {16'hFE00, 16'h0000});
    check_eq("t2_right", right, 16'h0000);
    check_counts("t2");

    // 3: short slot
    send_slot(1'b0, 10'h0AA, 3'd2, 12, 1);
    idle(3);
    e_f = e_f + 1;
    check_eq("t3_left", left, 16'h7FC0);
    check_counts("t3");

    // 4: overlapping strobes abort the slot
    sh1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      so = k[0];
      step(1);
    end
    sh2 = 1'b1;
    step(1);
    step(1);
    step(1);
    sh1 = 1'b0;
    step(1);
    step(1);
    e_f = e_f + 1;
    check_counts("t4_err");
    sh2 = 1'b0;
    idle(2);
    check_eq("t4_left_kept", left, 16'h7FC0);
    send_slot(1'b0, 10'h001, 3'd3, 16, 1);
    idle(3);
    e_l = e_l + 1;
    check_eq("t4_left", left, 16'h0004);
    check_counts("t4");

    // 5: sparse bit clock, L then R
    send_slot(1'b0, 10'h155, 3'd5, 16, 4);
    send_slot(1'b1, 10'h155, 3'd5, 16, 4);
    idle(4);
    e_l = e_l + 1;
    e_r = e_r + 1;
    check_eq("t5_left", left, 16'h1550);
    check_eq("t5_right", right, 16'h1550);
    check_eq("t5_order", (t_r > t_l), 1'b1);
    check_eq("t5_width", n_wide, 0);
    check_counts("t5");

    // 7: overlong slot, long enough that a wrapping counter would read 16
    send_slot(1'b0, 10'h0F0, 3'd4, 48, 1);
    idle(3);
    e_f = e_f + 1;
    check_eq("t7_left", left, 16'h1550);
    check_counts("t7");

    // 6: reset mid right slot
    sh2 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      so = ~k[0];
      step(1);
    end
    rst_n = 1'b0;
    #2;
    check_eq("t6_left_rst", left, 16'h0000);
    check_eq("t6_right_rst", right, 16'h0000);
    sh2 = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    idle(2);
    send_slot(1'b1, 10'h3FF, 3'd2, 16, 1);
    idle(3);
    e_r = e_r + 1;
    check_eq("t6_right", right, 16'hFFFE);
    check_eq("t6_left", left, 16'h0000);
    check_eq("t6_width", n_wide, 0);
    check_counts("t6");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
